// File: rtl/pulse_meter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_meter_pkg
// Shared constants for the pulse period meter: FSM state encodings, the
// default counter width and the saturation value for that width.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pulse_meter_pkg;

    localparam int WIDTH_DEF = 8;

    // Saturation value of the period counter at the default width.
    localparam logic [WIDTH_DEF-1:0] CNT_MAX = {WIDTH_DEF{1'b1}};

    // FSM encodings (plain constants for legacy tool compatibility).
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_MEASURE  = 2'd1;
    localparam state_t ST_OVERFLOW = 2'd2;

endpackage

// File: rtl/pulse_period_meter_if.sv
// -----------------------------------------------------------------------------
// pulse_period_meter_if
// Bundles the pulse input, the expected period and the measurement results.
//   pulse       : monitored pulse stream
//   exp_period  : expected period, sampled on edge cycles only
//   period      : last measured period (held)
//   valid       : one-cycle strobe when period updates
//   match       : period == exp_period at the last update (held)
//   locked      : two consecutive equal, non-overflow periods seen
//   ovf         : counter saturated without an edge
// Modports: master (stimulus / consumer side), slave (the meter).
// -----------------------------------------------------------------------------
interface pulse_period_meter_if
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             pulse;
    logic [WIDTH-1:0] exp_period;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             match;
    logic             locked;
    logic             ovf;

    modport master (
        output pulse, exp_period,
        input  period, valid, match, locked, ovf
    );

    modport slave (
        input  pulse, exp_period,
        output period, valid, match, locked, ovf
    );
endinterface

// File: rtl/pulse_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_edge_detect
// Optional 2-flop synchronizer followed by a rising-edge detector.
//   clk        : clock
//   rst        : synchronous active-low reset
//   pulse      : raw pulse input
//   pulse_edge : combinational, high for one cycle on each rising edge
// Build option: define PULSE_METER_SYNC_EN to insert the synchronizer (adds two
// cycles of latency, periods unchanged). Without it, pulse must already be
// synchronous to clk.
// -----------------------------------------------------------------------------
module pulse_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic pulse_edge
);

    logic pulse_s;
    logic pulse_d;
    logic pulse_q;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    // Next state of the two synchronizer stages.
    always_comb begin
        sync1_d = pulse;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pulse_s = sync2_q;
`else
    assign pulse_s = pulse;
`endif

    // Delayed copy used for edge detection.
    always_comb begin
        pulse_d = pulse_s;
    end

    // Previous-cycle pulse level; cleared so a level still high after reset
    // registers as an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_edge = pulse_s & ~pulse_q;

endmodule

// File: rtl/pulse_period_meter.sv
// -----------------------------------------------------------------------------
// pulse_period_meter
// Measures the number of clk cycles between consecutive rising edges of a
// pulse stream, reports each period with a one-cycle strobe, compares it with
// an expected value, and flags lock and timeout.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-low reset
//   bus : pulse_period_meter_if.slave (pulse, exp_period in; period, valid,
//         match, locked, ovf out, all outputs registered)
// Build option: PULSE_METER_SYNC_EN (see pulse_edge_detect) lets pulse come
// from an asynchronous source at the cost of two extra cycles of latency.
// -----------------------------------------------------------------------------
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_period_meter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_CNT  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_CNT  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};

    logic             pulse_edge;

    state_t           state_d,   state_q;
    logic [WIDTH-1:0] cnt_d,     cnt_q;
    logic             prev_ok_d, prev_ok_q;
    logic [WIDTH-1:0] period_d,  period_q;
    logic             valid_d,   valid_q;
    logic             match_d,   match_q;
    logic             locked_d,  locked_q;
    logic             ovf_d,     ovf_q;

    pulse_edge_detect u_edge (
        .clk        (clk),
        .rst        (rst),
        .pulse      (bus.pulse),
        .pulse_edge (pulse_edge)
    );

    // FSM, period counter and result next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_ok_d = prev_ok_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        match_d   = match_q;
        locked_d  = locked_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // The first edge only arms the meter; no result yet.
                if (pulse_edge) begin
                    state_d = ST_MEASURE;
                    cnt_d   = ONE_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MEASURE: begin
                // ovf from a preceding overflow update drops here.
                ovf_d = 1'b0;
                if (pulse_edge) begin
                    period_d  = cnt_q;
                    valid_d   = 1'b1;
                    match_d   = (cnt_q == bus.exp_period);
                    // Lock needs a previous period that was a real measurement.
                    locked_d  = prev_ok_q && (cnt_q == period_q);
                    prev_ok_d = 1'b1;
                    cnt_d     = ONE_CNT;
                end else if (cnt_q == MAX_CNT) begin
                    state_d  = ST_OVERFLOW;
                    ovf_d    = 1'b1;
                    locked_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end

            ST_OVERFLOW: begin
                if (pulse_edge) begin
                    // Report the saturated value; ovf stays set for this update.
                    period_d  = MAX_CNT;
                    valid_d   = 1'b1;
                    match_d   = (MAX_CNT == bus.exp_period);
                    locked_d  = 1'b0;
                    prev_ok_d = 1'b0;
                    cnt_d     = ONE_CNT;
                    state_d   = ST_MEASURE;
                end else begin
                    cnt_d = MAX_CNT;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = ZERO_CNT;
                prev_ok_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= ZERO_CNT;
            prev_ok_q <= 1'b0;
            period_q  <= ZERO_CNT;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            locked_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_ok_q <= prev_ok_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            locked_q  <= locked_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.period = period_q;
    assign bus.valid  = valid_q;
    assign bus.match  = match_q;
    assign bus.locked = locked_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Receive-side companion to the team's loadable 8-bit pulse counter. Watches a single-bit pulse stream and measures the interval, in `clk` cycles, between consecutive rising edges. Reports each measured period with a one-cycle valid strobe, compares it to an expected value, flags lock and timeout, and feeds counter self-checks and rate monitoring.

## Interface
Parameters:
- `WIDTH`, 8, width of the period counter and result; maximum measurable period is 2^WIDTH-1.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pulse` input 1: monitored pulse stream, same clock domain unless `PULSE_METER_SYNC_EN` is defined.
- `expect` input WIDTH: expected period, compared on each measurement.
- `period` output WIDTH: last measured period, held between measurements.
- `valid` output 1: one-cycle strobe, high when `period` updates.
- `match` output 1: `period == expect`, registered with `valid`, held until the next update.
- `locked` output 1: high after two consecutive equal, non-overflow periods.
- `ovf` output 1: timeout flag, the counter saturated without an edge.

## Operation
- Edge detect: `pulse_q` is `pulse` registered. `edge = pulse & ~pulse_q`.
- States:
  - IDLE: waiting for the first edge.
  - MEASURE: counting between edges.
  - OVERFLOW: counter saturated.
- Transitions:
  - IDLE -> MEASURE on `edge`. `cnt <= 1`. No `valid` is produced, because the first edge only arms the meter.
  - MEASURE, no edge: `cnt <= cnt+1`.
  - MEASURE, `cnt == 2^WIDTH-1` and no edge: go to OVERFLOW. Set `ovf <= 1` and `locked <= 0`.
  - MEASURE, `edge`:
    - `period <= cnt`, `valid <= 1`, `match <= (cnt == expect)`, `cnt <= 1`.
    - `locked <= (cnt == period)`, where `period` is the previous value. If `prev_ok` is clear, `locked <= 0`. Then `prev_ok <= 1`.
  - OVERFLOW: `cnt` holds at max. On `edge`: `period <= 2^WIDTH-1`, `valid <= 1`, `match` is evaluated normally, `ovf` stays 1 for that update, `prev_ok <= 0`, `cnt <= 1`. Next state is MEASURE, and `ovf` clears on the cycle after `valid`.
- Result: N cycles between rising edges gives `period = N`. Minimum measurable N is 2. A `pulse` held constantly high yields no edges and ends in OVERFLOW.
- Arithmetic is unsigned WIDTH-bit. `cnt` never wraps; it saturates.
- Reset (`rst == 0`) wins over everything, including mid-measurement:
  - state = IDLE, `cnt = 0`, `pulse_q = 0`, `prev_ok = 0`.
  - Outputs `period = 0`, `valid = 0`, `match = 0`, `locked = 0`, `ovf = 0`.
- Reset with `pulse` high: `pulse_q` is cleared, so if `pulse` is still high after reset, the first post-reset cycle registers an edge (arming only).
- `expect` may change at any time. It is sampled only on edge cycles.

## Timing
- `edge` is combinational in cycle t, where `pulse = 1` and `pulse_q = 0`. `valid`, `period`, `match` and `locked` are registered at t+1.
- Latency from `pulse` rising to `valid` is 1 cycle, or 3 cycles with `PULSE_METER_SYNC_EN`.
- `valid` is exactly one cycle wide. Back-to-back strobes occur every N cycles for N >= 2.
- `ovf` rises on the cycle after `cnt` reaches max with no edge.

## Configuration
- `PULSE_METER_SYNC_EN`:
  - Defined: `pulse` passes through a 2-flop synchronizer before edge detection. This permits an asynchronous source, adds 2 cycles latency and leaves measured periods unchanged. Synchronizer flops reset to 0.
  - Undefined: `pulse` is used directly and must be synchronous to `clk`.

## Structure
- Package `pulse_meter_pkg`:
  - state enumeration IDLE/MEASURE/OVERFLOW.
  - default `WIDTH` constant.
  - `CNT_MAX` = 2^WIDTH-1.
- Sub-module `pulse_edge_detect`: optional synchronizer plus rising-edge detector. Ports `clk`, `rst`, `pulse`, `edge`. Holds the `PULSE_METER_SYNC_EN` logic.
- Top level holds the FSM, counter and output registers.

## Test plan
- Reset then pulse every 10 cycles, `expect = 10`, for five edges:
  - first edge gives no `valid`.
  - then four `valid` strobes with `period = 10` and `match = 1`.
  - `locked` is 0 on the first strobe and 1 from the second.
- Pulse period 10, 10, then 7, `expect = 10`:
  - third strobe has `period = 7`, `match = 0`, `locked = 0`.
  - next 7 gives `locked = 1`.
- Single edge, then no pulse for 300 cycles:
  - `ovf = 1` from 256 cycles after the arming edge, `locked = 0`.
  - next edge gives `period = 255`, `valid = 1`, `ovf` clears one cycle later.
- Pulse toggling every cycle (period 2), then `pulse` held high: `period = 2` repeatedly, then OVERFLOW.
- `rst` asserted for 1 cycle mid-measurement (`cnt = 5`):
  - all outputs 0 the next cycle.
  - the next edge only arms.
  - a period of 10 is reported correctly afterwards.
- With `PULSE_METER_SYNC_EN`: repeat the first scenario; `valid` appears 3 cycles after each `pulse` rise and periods are unchanged.
